// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared constants, state type and Morse pattern lookup
package morse_pkg;
    localparam logic       SYM_DOT          = 1'b0;
    localparam logic       SYM_DASH         = 1'b1;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ERR_CHAR_DEFAULT = 8'h3F;
    localparam int         LEN_W            = 4;
    localparam int         PAT_W            = 8;

    typedef enum logic {IDLE, EMIT_SPACE} state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } lookup_t;

    // Patterns are written LSB-first: bit 0 is the first received symbol.
    function automatic lookup_t morse_lookup(input logic [PAT_W-1:0] pattern,
                                             input logic [LEN_W-1:0] len);
        lookup_t r;
        r.hit = 1'b1;
        case ({len, pattern})
            {4'd2, 8'b00000010}: r.ascii = 8'h41;
            {4'd4, 8'b00000001}: r.ascii = 8'h42;
            {4'd4, 8'b00000101}: r.ascii = 8'h43;
            {4'd3, 8'b00000001}: r.ascii = 8'h44;
            {4'd1, 8'b00000000}: r.ascii = 8'h45;
            {4'd4, 8'b00000100}: r.ascii = 8'h46;
            {4'd3, 8'b00000011}: r.ascii = 8'h47;
            {4'd4, 8'b00000000}: r.ascii = 8'h48;
            {4'd2, 8'b00000000}: r.ascii = 8'h49;
            {4'd4, 8'b00001110}: r.ascii = 8'h4A;
            {4'd3, 8'b00000101}: r.ascii = 8'h4B;
            {4'd4, 8'b00000010}: r.ascii = 8'h4C;
            {4'd2, 8'b00000011}: r.ascii = 8'h4D;
            {4'd2, 8'b00000001}: r.ascii = 8'h4E;
            {4'd3, 8'b00000111}: r.ascii = 8'h4F;
            {4'd4, 8'b00000110}: r.ascii = 8'h50;
            {4'd4, 8'b00001011}: r.ascii = 8'h51;
            {4'd3, 8'b00000010}: r.ascii = 8'h52;
            {4'd3, 8'b00000000}: r.ascii = 8'h53;
            {4'd1, 8'b00000001}: r.ascii = 8'h54;
            {4'd3, 8'b00000100}: r.ascii = 8'h55;
            {4'd4, 8'b00001000}: r.ascii = 8'h56;
            {4'd3, 8'b00000110}: r.ascii = 8'h57;
            {4'd4, 8'b00001001}: r.ascii = 8'h58;
            {4'd4, 8'b00001101}: r.ascii = 8'h59;
            {4'd4, 8'b00000011}: r.ascii = 8'h5A;
            {4'd5, 8'b00011111}: r.ascii = 8'h30;
            {4'd5, 8'b00011110}: r.ascii = 8'h31;
            {4'd5, 8'b00011100}: r.ascii = 8'h32;
            {4'd5, 8'b00011000}: r.ascii = 8'h33;
            {4'd5, 8'b00010000}: r.ascii = 8'h34;
            {4'd5, 8'b00000000}: r.ascii = 8'h35;
            {4'd5, 8'b00000001}: r.ascii = 8'h36;
            {4'd5, 8'b00000011}: r.ascii = 8'h37;
            {4'd5, 8'b00000111}: r.ascii = 8'h38;
            {4'd5, 8'b00001111}: r.ascii = 8'h39;
            {4'd6, 8'b00101010}: r.ascii = 8'h2E;
            {4'd6, 8'b00110011}: r.ascii = 8'h2C;
            {4'd6, 8'b00001100}: r.ascii = 8'h3F;
            {4'd5, 8'b00001001}: r.ascii = 8'h2F;
            {4'd5, 8'b00010001}: r.ascii = 8'h3D;
            {4'd6, 8'b00100001}: r.ascii = 8'h2D;
            {4'd5, 8'b00001101}: r.ascii = 8'h28;
            {4'd6, 8'b00101101}: r.ascii = 8'h29;
            {4'd6, 8'b00011110}: r.ascii = 8'h27;
            {4'd6, 8'b00000111}: r.ascii = 8'h3A;
            {4'd6, 8'b00010010}: r.ascii = 8'h22;
            {4'd6, 8'b00010110}: r.ascii = 8'h40;
            default: begin
                r.hit   = 1'b0;
                r.ascii = 8'h00;
            end
        endcase
        return r;
    endfunction
endpackage

// File: rtl/morse_decoder_buf_if.sv
// rtl/morse_decoder_buf_if.sv - decoded character stream handshake
interface morse_decoder_buf_if;
    logic [7:0] sout;
    logic       sout_valid;
    logic       sout_ready;

    modport master (output sout, output sout_valid, input sout_ready);
    modport slave  (input sout, input sout_valid, output sout_ready);
endinterface

// File: rtl/morse_char_fifo.sv
// rtl/morse_char_fifo.sv - show-ahead character FIFO with registered head and sticky overflow
module morse_char_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop_ready,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push_ok;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == (AW+1)'(DEPTH));
        pop        = !empty && pop_ready;
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q || (push && full && !pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop)
            count_d = count_q + 1'b1;
        else if (!push_ok && pop)
            count_d = count_q - 1'b1;
        // Head is registered so it keeps the last popped value once empty.
        head_d = head_q;
        if (pop) begin
            if (count_q > (AW+1)'(1))
                head_d = mem_q[rd_ptr_q + 1'b1];
            else if (push_ok)
                head_d = push_data;
        end else if (empty && push_ok) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = head_q;
    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: rtl/morse_decoder_buf.sv
// rtl/morse_decoder_buf.sv - Morse symbol accumulator, ASCII translation and word-space insertion
module morse_decoder_buf
    import morse_pkg::*;
#(
    parameter int         MAX_SYMBOLS     = 6,
    parameter int         FIFO_DEPTH      = 8,
    parameter logic [7:0] ERR_CHAR        = ERR_CHAR_DEFAULT,
    parameter bit         COLLAPSE_SPACES = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dot_inp,
    input  logic                        dash_inp,
    input  logic                        char_space_inp,
    input  logic                        word_space_inp,
    morse_decoder_buf_if.master         sout_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        sym_err
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMBOLS);

    logic [PAT_W-1:0] pat_q, pat_d, pat_a;
    logic [LEN_W-1:0] len_q, len_d, len_a;
    logic             bad_q, bad_d, bad_a;
    state_t           state_q, state_d;
    logic             last_was_space_q, last_was_space_d;
    logic             sym_err_q, sym_err_d;
    logic             pending, char_err, take_char, push, push_err, fifo_empty;
    logic [7:0]       char_data, push_data;
    lookup_t          lk;

    always_comb begin
        // Same-cycle symbol is folded in before any terminating event is evaluated.
        pat_a = pat_q;
        len_a = len_q;
        bad_a = bad_q || (dot_inp && dash_inp);
        if (dot_inp ^ dash_inp) begin
            if (len_q == MAX_LEN) begin
                bad_a = 1'b1;
            end else begin
                pat_a[len_q[2:0]] = dash_inp ? SYM_DASH : SYM_DOT;
                len_a = len_q + 1'b1;
            end
        end
        pending   = (len_a != '0) || bad_a;
        lk        = morse_lookup(pat_a, len_a);
        char_err  = bad_a || !lk.hit;
        char_data = char_err ? ERR_CHAR : lk.ascii;

        state_d   = state_q;
        take_char = 1'b0;
        push      = 1'b0;
        case (state_q)
            EMIT_SPACE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                if (word_space_inp) begin
                    if (pending) begin
                        take_char = 1'b1;
                        state_d   = EMIT_SPACE;
                    end else if (!(COLLAPSE_SPACES && last_was_space_q)) begin
                        push = 1'b1;
                    end
                end else if (char_space_inp && pending) begin
                    take_char = 1'b1;
                end
            end
        endcase

        push      = push || take_char;
        push_data = take_char ? char_data : ASCII_SPACE;
        push_err  = take_char && char_err;
        pat_d     = take_char ? '0 : pat_a;
        len_d     = take_char ? '0 : len_a;
        bad_d     = take_char ? 1'b0 : bad_a;
        last_was_space_d = push ? !take_char : last_was_space_q;
        sym_err_d = push_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q            <= '0;
            len_q            <= '0;
            bad_q            <= 1'b0;
            state_q          <= IDLE;
            last_was_space_q <= 1'b0;
            sym_err_q        <= 1'b0;
        end else begin
            pat_q            <= pat_d;
            len_q            <= len_d;
            bad_q            <= bad_d;
            state_q          <= state_d;
            last_was_space_q <= last_was_space_d;
            sym_err_q        <= sym_err_d;
        end
    end

    morse_char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop_ready (sout_if.sout_ready),
        .head      (sout_if.sout),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign sout_if.sout_valid = !fifo_empty;
    assign sym_err            = sym_err_q;
endmodule
